// File: rtl/mem_stage.sv
// RV32I memory stage: one data-memory request per load/store, stall until response, load align/extend.
// Optional performance counters are enabled by defining MEM_STAGE_PERF_EN.
package mem_stage_pkg;

    typedef struct packed {
        logic        commit;
        logic [63:0] order;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [4:0]  rd_addr;
        logic [31:0] rd_v;
        logic        regf_we;
        logic [31:0] dmem_addr;
        logic [3:0]  dmem_rmask;
        logic [3:0]  dmem_wmask;
        logic [31:0] dmem_wdata;
    } ex_mem_reg_t;

    typedef struct packed {
        logic        commit;
        logic [63:0] order;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [4:0]  rd_addr;
        logic [31:0] rd_v;
        logic        regf_we;
        logic [31:0] dmem_addr;
        logic [3:0]  dmem_rmask;
        logic [3:0]  dmem_wmask;
        logic [31:0] dmem_wdata;
        logic [31:0] dmem_rdata;
    } mem_wb_reg_t;

endpackage

module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int STALL_TIMEOUT = 1023,
    parameter int PERF_W        = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  ex_mem_reg_t       ex_mem_reg,
    output logic [31:0]       dmem_addr,
    output logic [3:0]        dmem_rmask,
    output logic [3:0]        dmem_wmask,
    output logic [31:0]       dmem_wdata,
    input  logic [31:0]       dmem_rdata,
    input  logic              dmem_resp,
    output logic              mem_stall,
    output mem_wb_reg_t       mem_wb_reg,
    output logic              mem_err
`ifdef MEM_STAGE_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_loads,
    output logic [PERF_W-1:0] perf_stores,
    output logic [PERF_W-1:0] perf_stall_cycles
`endif
);

    localparam logic [9:0] TIMEOUT_LIM = 10'(STALL_TIMEOUT);
    localparam bit         TIMEOUT_ON  = (STALL_TIMEOUT != 0);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t      state, state_next;
    ex_mem_reg_t req_p0;
    mem_wb_reg_t mem_wb_next;
    logic [9:0]  wait_cnt, wait_cnt_inc;
    logic        memop, capture, resp_done, timeout_hit;

    function automatic mem_wb_reg_t to_wb(input ex_mem_reg_t ex);
        mem_wb_reg_t r;
        r.commit     = ex.commit;
        r.order      = ex.order;
        r.pc         = ex.pc;
        r.inst       = ex.inst;
        r.rd_addr    = ex.rd_addr;
        r.rd_v       = ex.rd_v;
        r.regf_we    = ex.regf_we;
        r.dmem_addr  = ex.dmem_addr;
        r.dmem_rmask = ex.dmem_rmask;
        r.dmem_wmask = ex.dmem_wmask;
        r.dmem_wdata = ex.dmem_wdata;
        r.dmem_rdata = '0;
        return r;
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] funct3, input logic [1:0] off,
                                                input logic [31:0] word);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b = 8'(word >> {off, 3'b000});
        h = off[1] ? word[31:16] : word[15:0];
        unique case (funct3)
            3'b000:  return 32'(b);
            3'b100:  return {24'b0, b};
            3'b001:  return 32'(h);
            3'b101:  return {16'b0, h};
            default: return word;
        endcase
    endfunction

    function automatic mem_wb_reg_t resp_record(input ex_mem_reg_t ex, input logic [31:0] rdata);
        mem_wb_reg_t r;
        r            = to_wb(ex);
        r.commit     = 1'b1;
        r.dmem_rdata = rdata;
        if (|ex.dmem_rmask) begin
            r.rd_v = load_extend(ex.inst[14:12], ex.dmem_addr[1:0], rdata);
        end else begin
            r.rd_v    = '0;
            r.regf_we = 1'b0;
        end
        return r;
    endfunction

    // Masks are qualified by reset so nothing is requested while rst is held low.
    assign memop        = rst && ex_mem_reg.commit && (|(ex_mem_reg.dmem_rmask | ex_mem_reg.dmem_wmask));
    assign resp_done    = (state == S_WAIT) && dmem_resp;
    assign wait_cnt_inc = (&wait_cnt) ? wait_cnt : wait_cnt + 10'd1;
    assign timeout_hit  = TIMEOUT_ON && (state == S_WAIT) && !dmem_resp && (wait_cnt_inc >= TIMEOUT_LIM);

    always_comb begin
        state_next  = state;
        mem_stall   = 1'b0;
        capture     = 1'b0;
        dmem_addr   = {req_p0.dmem_addr[31:2], 2'b00};
        dmem_wdata  = req_p0.dmem_wdata;
        dmem_rmask  = 4'b0;
        dmem_wmask  = 4'b0;
        mem_wb_next = '0;
        unique case (state)
            S_IDLE: begin
                dmem_addr  = {ex_mem_reg.dmem_addr[31:2], 2'b00};
                dmem_wdata = ex_mem_reg.dmem_wdata;
                if (memop) begin
                    dmem_rmask = ex_mem_reg.dmem_rmask;
                    dmem_wmask = ex_mem_reg.dmem_wmask;
                    mem_stall  = 1'b1;
                    capture    = 1'b1;
                    state_next = S_WAIT;
                end else begin
                    mem_wb_next = to_wb(ex_mem_reg);
                end
            end
            S_WAIT: begin
                if (dmem_resp) begin
                    mem_wb_next = resp_record(req_p0, dmem_rdata);
                    state_next  = S_IDLE;
                end else begin
                    mem_stall = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Stage boundary: control state, registered writeback record and timeout tracking.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            mem_wb_reg <= '0;
            wait_cnt   <= '0;
            mem_err    <= 1'b0;
        end else begin
            state      <= state_next;
            mem_wb_reg <= mem_wb_next;
            if (capture) begin
                wait_cnt <= '0;
            end else if ((state == S_WAIT) && !dmem_resp) begin
                wait_cnt <= wait_cnt_inc;
            end
            if (timeout_hit) begin
                mem_err <= 1'b1;
            end
        end
    end

    // Request record is held for the whole wait so address and store data stay stable.
    always_ff @(posedge clk) begin
        if (capture) begin
            req_p0 <= ex_mem_reg;
        end
    end

`ifdef MEM_STAGE_PERF_EN
    function automatic logic [PERF_W-1:0] perf_inc(input logic [PERF_W-1:0] v);
        return (&v) ? v : v + {{(PERF_W-1){1'b0}}, 1'b1};
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_loads        <= '0;
            perf_stores       <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (resp_done && (|req_p0.dmem_rmask)) begin
                perf_loads <= perf_inc(perf_loads);
            end
            if (resp_done && !(|req_p0.dmem_rmask)) begin
                perf_stores <= perf_inc(perf_stores);
            end
            if (mem_stall) begin
                perf_stall_cycles <= perf_inc(perf_stall_cycles);
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed plus randomized bench for mem_stage with a transaction-level reference model.
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam int TO = 4;

    logic        clk;
    logic        rst;
    ex_mem_reg_t ex_in;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_rmask;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;
    logic        mem_stall;
    mem_wb_reg_t mem_wb_reg;
    logic        mem_err;

    int   checks   = 0;
    int   failures = 0;
    logic exp_err  = 1'b0;
    logic [63:0] order_ctr = 64'd0;

    mem_stage #(.STALL_TIMEOUT(TO), .PERF_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .ex_mem_reg (ex_in),
        .dmem_addr  (dmem_addr),
        .dmem_rmask (dmem_rmask),
        .dmem_wmask (dmem_wmask),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_resp  (dmem_resp),
        .mem_stall  (mem_stall),
        .mem_wb_reg (mem_wb_reg),
        .mem_err    (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [287:0] obs, input logic [287:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] w);
        int unsigned sh = (addr % 4) * 8;
        int unsigned hs = ((addr % 4) >= 2) ? 16 : 0;
        logic [31:0] b = (w >> sh) & 32'hFF;
        logic [31:0] h = (w >> hs) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
            3'd4:    return b;
            3'd1:    return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    function automatic mem_wb_reg_t ref_pass(input ex_mem_reg_t e);
        mem_wb_reg_t r;
        r = '0;
        r.commit = e.commit;   r.order = e.order;       r.pc = e.pc;
        r.inst = e.inst;       r.rd_addr = e.rd_addr;   r.rd_v = e.rd_v;
        r.regf_we = e.regf_we; r.dmem_addr = e.dmem_addr;
        r.dmem_rmask = e.dmem_rmask; r.dmem_wmask = e.dmem_wmask; r.dmem_wdata = e.dmem_wdata;
        return r;
    endfunction

    function automatic ex_mem_reg_t mk(input logic commit, input logic [2:0] f3, input logic [31:0] addr,
                                       input logic [3:0] rm, input logic [3:0] wm,
                                       input logic [31:0] wd, input logic [31:0] rdv);
        ex_mem_reg_t e;
        e = '0;
        e.commit = commit;
        e.pc = $urandom;
        e.inst = $urandom;
        e.inst[14:12] = f3;
        e.rd_addr = 5'($urandom);
        e.rd_v = rdv;
        e.regf_we = 1'b1;
        e.dmem_addr = addr;
        e.dmem_rmask = rm;
        e.dmem_wmask = wm;
        e.dmem_wdata = wd;
        return e;
    endfunction

    // A non-memory record: one cycle, no stall, copied to writeback.
    task automatic do_pass(input ex_mem_reg_t e, input logic stray_resp);
        ex_in = e;
        ex_in.order = order_ctr;
        order_ctr++;
        dmem_resp = stray_resp;
        dmem_rdata = $urandom;
        @(negedge clk);
        chk("pass_stall", 288'(mem_stall), 288'(1'b0));
        chk("pass_masks", 288'({dmem_rmask, dmem_wmask}), 288'(8'h00));
        @(posedge clk); #1;
        dmem_resp = 1'b0;
        chk("pass_record", 288'(mem_wb_reg), 288'(ref_pass(ex_in)));
        chk("pass_err", 288'(mem_err), 288'(exp_err));
    endtask

    // A load/store: request cycle, 'delay' cycles without response, then the response cycle.
    task automatic do_mem(input ex_mem_reg_t e, input int delay, input logic [31:0] rdata);
        mem_wb_reg_t exp_rec;
        int waits = 0;
        int commits = 0;
        ex_in = e;
        ex_in.order = order_ctr;
        order_ctr++;
        dmem_resp = 1'b0;
        @(negedge clk);
        chk("req_addr", 288'(dmem_addr), 288'(ex_in.dmem_addr & 32'hFFFF_FFFC));
        chk("req_masks", 288'({dmem_rmask, dmem_wmask}), 288'({ex_in.dmem_rmask, ex_in.dmem_wmask}));
        chk("req_wdata", 288'(dmem_wdata), 288'(ex_in.dmem_wdata));
        chk("req_stall", 288'(mem_stall), 288'(1'b1));
        @(posedge clk); #1;
        commits += int'(mem_wb_reg.commit);
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            chk("wait_masks", 288'({dmem_rmask, dmem_wmask}), 288'(8'h00));
            chk("wait_addr", 288'(dmem_addr), 288'(ex_in.dmem_addr & 32'hFFFF_FFFC));
            chk("wait_wdata", 288'(dmem_wdata), 288'(ex_in.dmem_wdata));
            chk("wait_stall", 288'(mem_stall), 288'(1'b1));
            @(posedge clk); #1;
            waits++;
            if (waits >= TO) exp_err = 1'b1;
            commits += int'(mem_wb_reg.commit);
            chk("wait_err", 288'(mem_err), 288'(exp_err));
        end
        dmem_resp = 1'b1;
        dmem_rdata = rdata;
        @(negedge clk);
        chk("resp_stall", 288'(mem_stall), 288'(1'b0));
        @(posedge clk); #1;
        dmem_resp = 1'b0;
        commits += int'(mem_wb_reg.commit);
        exp_rec = ref_pass(ex_in);
        exp_rec.commit = 1'b1;
        exp_rec.dmem_rdata = rdata;
        if (ex_in.dmem_rmask != 4'h0) begin
            exp_rec.rd_v = ref_load(ex_in.inst[14:12], ex_in.dmem_addr, rdata);
        end else begin
            exp_rec.rd_v = 32'h0;
            exp_rec.regf_we = 1'b0;
        end
        chk("resp_record", 288'(mem_wb_reg), 288'(exp_rec));
        chk("resp_commits", 288'(commits), 288'(1));
        chk("resp_err", 288'(mem_err), 288'(exp_err));
        ex_in = '0;
    endtask

    initial begin
        ex_mem_reg_t e;
        logic [2:0]  ld_f3 [5];
        int          kind;
        ld_f3[0] = 3'd0; ld_f3[1] = 3'd1; ld_f3[2] = 3'd2; ld_f3[3] = 3'd4; ld_f3[4] = 3'd5;

        rst = 1'b0;
        ex_in = '0;
        dmem_rdata = '0;
        dmem_resp = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_record", 288'(mem_wb_reg), 288'(0));
        chk("rst_err", 288'(mem_err), 288'(1'b0));
        chk("rst_stall", 288'(mem_stall), 288'(1'b0));
        chk("rst_masks", 288'({dmem_rmask, dmem_wmask}), 288'(8'h00));
        rst = 1'b1;

        do_pass(mk(1'b1, 3'd0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h5), 1'b0);
        do_mem(mk(1'b1, 3'd0, 32'h1003, 4'h8, 4'h0, 32'h0, 32'h0), 3, 32'h80FF_FFFF);
        do_mem(mk(1'b1, 3'd5, 32'h2002, 4'hC, 4'h0, 32'h0, 32'h0), 1, 32'hBEEF_1234);
        do_mem(mk(1'b1, 3'd2, 32'h3000, 4'hF, 4'h0, 32'h0, 32'h0), 0, 32'hDEAD_BEEF);
        do_mem(mk(1'b1, 3'd2, 32'h4000, 4'h0, 4'hF, 32'h1234_5678, 32'h77), 0, 32'h0);
        do_pass(mk(1'b1, 3'd0, 32'h0, 4'h0, 4'h0, 32'h0, 32'hABCD), 1'b1);

        for (int n = 0; n < 80; n++) begin
            kind = int'($urandom_range(0, 4));
            case (kind)
                0: do_pass(mk(1'b1, 3'($urandom), $urandom, 4'h0, 4'h0, $urandom, $urandom), 1'($urandom));
                1: do_pass(mk(1'b0, 3'($urandom), $urandom, 4'($urandom), 4'($urandom), $urandom, $urandom), 1'($urandom));
                2, 3: do_mem(mk(1'b1, ld_f3[$urandom_range(0, 4)], $urandom, 4'($urandom_range(1, 15)), 4'h0,
                                $urandom, $urandom), int'($urandom_range(0, TO - 1)), $urandom);
                default: do_mem(mk(1'b1, 3'd2, $urandom, 4'h0, 4'($urandom_range(1, 15)), $urandom, $urandom),
                                int'($urandom_range(0, TO - 1)), $urandom);
            endcase
        end

        do_mem(mk(1'b1, 3'd4, 32'h5001, 4'h2, 4'h0, 32'h0, 32'h0), TO + 2, 32'h0000_9A00);
        do_pass(mk(1'b1, 3'd0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h11), 1'b0);
        do_mem(mk(1'b1, 3'd1, 32'h6002, 4'hC, 4'h0, 32'h0, 32'h0), 1, 32'h8001_0002);

        ex_in = mk(1'b1, 3'd2, 32'h7000, 4'hF, 4'h0, 32'h0, 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        ex_in = '0;
        exp_err = 1'b0;
        #1;
        chk("midrst_stall", 288'(mem_stall), 288'(1'b0));
        chk("midrst_commit", 288'(mem_wb_reg.commit), 288'(1'b0));
        chk("midrst_err", 288'(mem_err), 288'(1'b0));
        @(posedge clk); #1;
        rst = 1'b1;
        dmem_resp = 1'b1;
        dmem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        chk("spur_stall", 288'(mem_stall), 288'(1'b0));
        chk("spur_masks", 288'({dmem_rmask, dmem_wmask}), 288'(8'h00));
        @(posedge clk); #1;
        dmem_resp = 1'b0;
        chk("spur_commit", 288'(mem_wb_reg.commit), 288'(1'b0));
        do_pass(mk(1'b1, 3'd0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h22), 1'b0);
        do_mem(mk(1'b1, 3'd0, 32'h8000, 4'h1, 4'h0, 32'h0, 32'h0), 2, 32'h0000_007F);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
